// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Grants are combinational; responses return one cycle after grant with per-master read-data hold.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic                      m0_req_i,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,
    input  logic                      m1_req_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
    output logic                      ram_bypass_en_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  last_gnt;     // 1'b1 = m1 was granted most recently
    logic                  resp_valid;
    logic                  resp_owner;   // 1'b1 = response belongs to m1
    logic                  resp_is_read;
    logic [DATA_WIDTH-1:0] m0_hold;
    logic [DATA_WIDTH-1:0] m1_hold;
    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;
    logic                  gnt_we;

    // Round-robin grant decision; reset forces both grants low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rstn_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (m0_req_i && m1_req_i) begin
            gnt0 = last_gnt;
            gnt1 = ~last_gnt;
        end else if (m0_req_i) begin
            gnt0 = 1'b1;
        end else if (m1_req_i) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // RAM command mux from the granted master; all zero when idle.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = {ADDR_WIDTH{1'b0}};
        ram_be_o    = {BE_WIDTH{1'b0}};
        ram_wdata_o = {DATA_WIDTH{1'b0}};
        gnt_we      = 1'b0;
        if (gnt0) begin
            ram_en_o    = 1'b1;
            ram_we_o    = m0_we_i;
            ram_addr_o  = m0_addr_i;
            ram_be_o    = m0_be_i;
            ram_wdata_o = m0_wdata_i;
            gnt_we      = m0_we_i;
        end else if (gnt1) begin
            ram_en_o    = 1'b1;
            ram_we_o    = m1_we_i;
            ram_addr_o  = m1_addr_i;
            ram_be_o    = m1_be_i;
            ram_wdata_o = m1_wdata_i;
            gnt_we      = m1_we_i;
        end else begin
            ram_en_o    = 1'b0;
            gnt_we      = 1'b0;
        end
    end

    // Priority and response tracking; an async reset discards any pending response.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            last_gnt     <= 1'b1;
            resp_valid   <= 1'b0;
            resp_owner   <= 1'b0;
            resp_is_read <= 1'b0;
        end else begin
            resp_valid <= any_gnt;
            if (any_gnt) begin
                last_gnt     <= gnt1;
                resp_owner   <= gnt1;
                resp_is_read <= ~gnt_we;
            end else begin
                last_gnt     <= last_gnt;
                resp_owner   <= resp_owner;
                resp_is_read <= resp_is_read;
            end
        end
    end

    // Per-master hold registers capture read data only on that master's read response.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            m0_hold <= {DATA_WIDTH{1'b0}};
            m1_hold <= {DATA_WIDTH{1'b0}};
        end else if (resp_valid && resp_is_read) begin
            if (resp_owner) begin
                m1_hold <= ram_rdata_i;
            end else begin
                m0_hold <= ram_rdata_i;
            end
        end else begin
            m0_hold <= m0_hold;
            m1_hold <= m1_hold;
        end
    end

    assign m0_rvalid_o = resp_valid & ~resp_owner;
    assign m1_rvalid_o = resp_valid & resp_owner;

    // Read data passes straight through on the owner's read response, otherwise the hold value.
    always_comb begin
        m0_rdata_o = m0_hold;
        m1_rdata_o = m1_hold;
        if (resp_valid && resp_is_read && !resp_owner) begin
            m0_rdata_o = ram_rdata_i;
        end else if (resp_valid && resp_is_read && resp_owner) begin
            m1_rdata_o = ram_rdata_i;
        end else begin
            m0_rdata_o = m0_hold;
            m1_rdata_o = m1_hold;
        end
    end

    assign ram_bypass_en_o = 1'b0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grants, responses and held read data.
module tb_ram_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          m0_req_i, m1_req_i, m0_we_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [BW-1:0] m0_be_i, m1_be_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          ram_en_o, ram_we_o, ram_bypass_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_bypass_en_o(ram_bypass_en_o)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_be_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_be_i = '0; m1_wdata_i = '0;
        ram_rdata_i = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic apply_reset();
        rstn_i = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        set_idle();
        m0_req_i = 1'b1; m1_req_i = 1'b1; m0_we_i = 1'b1;
        m0_addr_i = 15'h0123; m0_be_i = 4'hF; m0_wdata_i = 32'hCAFEF00D;
        ram_rdata_i = 32'h5555AAAA;
        @(posedge clk); #2;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, ram_en_o, ram_we_o, ram_bypass_en_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b%b rvalid=%b%b en=%b we=%b byp=%b want all 0",
                     m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, ram_en_o, ram_we_o, ram_bypass_en_o);
        end
        checks++;
        if ({ram_addr_o, ram_be_o, ram_wdata_o, m0_rdata_o, m1_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h be=%h wdata=%h rdata0=%h rdata1=%h want 0",
                     ram_addr_o, ram_be_o, ram_wdata_o, m0_rdata_o, m1_rdata_o);
        end
        set_idle();
        #1 rstn_i = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 15'h0010; m0_be_i = 4'hF;
        #2;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, ram_en_o, ram_we_o, ram_addr_o} !== {4'b1010, 15'h0010}) begin
            errors++;
            $display("FAIL read_cmd: gnt=%b%b en=%b we=%b addr=%h want 1 0 1 0 0010",
                     m0_gnt_o, m1_gnt_o, ram_en_o, ram_we_o, ram_addr_o);
        end
        @(posedge clk); #1;
        set_idle();
        ram_rdata_i = 32'hDEADBEEF;
        #2;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o, m0_gnt_o} !== 3'b100 || m0_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_resp: rvalid=%b%b gnt0=%b rdata0=%h want 1 0 0 deadbeef",
                     m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m0_rdata_o);
        end
        @(posedge clk); #1;
        ram_rdata_i = 32'h00000001;
        #2;
        checks++;
        if (m0_rvalid_o !== 1'b0 || m0_rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold: rvalid0=%b rdata0=%h want 0 deadbeef", m0_rvalid_o, m0_rdata_o);
        end
    endtask

    task automatic test_write();
        apply_reset();
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 15'h0020; m1_be_i = 4'b0011;
        m1_wdata_i = 32'h12345678;
        #2;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o}
            !== {4'b0111, 15'h0020, 4'b0011, 32'h12345678}) begin
            errors++;
            $display("FAIL write_cmd: gnt=%b%b en=%b we=%b addr=%h be=%b wdata=%h",
                     m0_gnt_o, m1_gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o);
        end
        @(posedge clk); #1;
        set_idle();
        ram_rdata_i = 32'hFFFFFFFF;
        #2;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01 || m1_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL write_resp: rvalid=%b%b rdata1=%h want 0 1 00000000",
                     m0_rvalid_o, m1_rvalid_o, m1_rdata_o);
        end
    endtask

    task automatic test_alternate();
        logic [DW-1:0] rd;
        int            prev_owner;
        apply_reset();
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        prev_owner = -1;
        for (int c = 0; c < 8; c++) begin
            rd = $urandom;
            ram_rdata_i = rd;
            m0_addr_i = AW'($urandom); m1_addr_i = AW'($urandom);
            #2;
            checks++;
            if ({m0_gnt_o, m1_gnt_o} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_gnt cycle %0d: gnt=%b%b want owner m%0d", c, m0_gnt_o, m1_gnt_o, c % 2);
            end
            if (prev_owner >= 0) begin
                checks++;
                if ({m0_rvalid_o, m1_rvalid_o} !== ((prev_owner == 0) ? 2'b10 : 2'b01) ||
                    (prev_owner == 0 ? m0_rdata_o : m1_rdata_o) !== rd) begin
                    errors++;
                    $display("FAIL alt_resp cycle %0d: rvalid=%b%b rdata0=%h rdata1=%h want m%0d data %h",
                             c, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, prev_owner, rd);
                end
            end
            prev_owner = c % 2;
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic test_hold_isolation();
        apply_reset();
        m0_req_i = 1'b1; m0_addr_i = 15'h0100;
        @(posedge clk); #1;
        set_idle();
        ram_rdata_i = 32'hA5A5A5A5;
        m1_req_i = 1'b1; m1_addr_i = 15'h0200;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++;
            if (m0_rdata_o !== 32'hA5A5A5A5 || m0_rvalid_o !== (c == 0)) begin
                errors++;
                $display("FAIL hold_iso cycle %0d: rdata0=%h rvalid0=%b want a5a5a5a5 %b",
                         c, m0_rdata_o, m0_rvalid_o, (c == 0));
            end
            @(posedge clk); #1;
            ram_rdata_i = 32'h11111111;
        end
        set_idle();
    endtask

    task automatic test_reset_pending();
        apply_reset();
        m0_req_i = 1'b1; m0_addr_i = 15'h0044;
        #2;
        checks++;
        if (m0_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rstpend_gnt: gnt0=%b want 1", m0_gnt_o);
        end
        #1 rstn_i = 1'b0;
        #1;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, ram_en_o, ram_we_o} !== 6'b0 ||
            ram_addr_o !== '0) begin
            errors++;
            $display("FAIL rstpend_out: gnt=%b%b rvalid=%b%b en=%b addr=%h want 0",
                     m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, ram_en_o, ram_addr_o);
        end
        @(posedge clk); #1;
        checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
            errors++;
            $display("FAIL rstpend_rvalid: rvalid=%b%b want 00", m0_rvalid_o, m1_rvalid_o);
        end
        rstn_i = 1'b1;
        m1_req_i = 1'b1;
        #2;
        checks++;
        if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o} !== 3'b100) begin
            errors++;
            $display("FAIL rstpend_first: gnt=%b%b rvalid0=%b want 1 0 0", m0_gnt_o, m1_gnt_o, m0_rvalid_o);
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic test_random();
        int            next_winner;
        bit            pend;
        int            pend_owner;
        bit            pend_read;
        logic [DW-1:0] hold [2];
        int            w;
        logic [1:0]    exp_gnt, exp_rv;
        logic [52:0]   exp_bus;
        logic [DW-1:0] exp_rd0, exp_rd1;
        apply_reset();
        next_winner = 0; pend = 1'b0; pend_owner = 0; pend_read = 1'b0;
        hold[0] = '0; hold[1] = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            m0_req_i = ($urandom_range(0, 3) != 0); m1_req_i = ($urandom_range(0, 3) != 0);
            m0_we_i = $urandom_range(0, 1); m1_we_i = $urandom_range(0, 1);
            m0_addr_i = AW'($urandom); m1_addr_i = AW'($urandom);
            m0_be_i = BW'($urandom); m1_be_i = BW'($urandom);
            m0_wdata_i = $urandom; m1_wdata_i = $urandom;
            ram_rdata_i = $urandom;
            #3;
            if (m0_req_i && m1_req_i) w = next_winner;
            else if (m0_req_i)        w = 0;
            else if (m1_req_i)        w = 1;
            else                      w = -1;
            exp_gnt = {w == 0, w == 1};
            if (w == 0)      exp_bus = {1'b1, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i};
            else if (w == 1) exp_bus = {1'b1, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i};
            else             exp_bus = '0;
            exp_rv  = {pend && pend_owner == 0, pend && pend_owner == 1};
            exp_rd0 = (pend && pend_read && pend_owner == 0) ? ram_rdata_i : hold[0];
            exp_rd1 = (pend && pend_read && pend_owner == 1) ? ram_rdata_i : hold[1];
            checks++;
            if ({m0_gnt_o, m1_gnt_o} !== exp_gnt) begin
                errors++;
                $display("FAIL rnd_gnt cycle %0d: got %b want %b", c, {m0_gnt_o, m1_gnt_o}, exp_gnt);
            end
            checks++;
            if ({ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o} !== exp_bus || ram_bypass_en_o !== 1'b0) begin
                errors++;
                $display("FAIL rnd_bus cycle %0d: got %h byp=%b want %h", c,
                         {ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o}, ram_bypass_en_o, exp_bus);
            end
            checks++;
            if ({m0_rvalid_o, m1_rvalid_o} !== exp_rv) begin
                errors++;
                $display("FAIL rnd_rvalid cycle %0d: got %b want %b", c, {m0_rvalid_o, m1_rvalid_o}, exp_rv);
            end
            checks++;
            if (m0_rdata_o !== exp_rd0 || m1_rdata_o !== exp_rd1) begin
                errors++;
                $display("FAIL rnd_rdata cycle %0d: got %h %h want %h %h", c, m0_rdata_o, m1_rdata_o, exp_rd0, exp_rd1);
            end
            if (pend && pend_read) hold[pend_owner] = ram_rdata_i;
            pend = (w >= 0);
            if (w >= 0) begin
                pend_owner  = w;
                pend_read   = (w == 0) ? !m0_we_i : !m1_we_i;
                next_winner = 1 - w;
            end
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_alternate();
        test_hold_isolation();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, byte-address width to RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width DATA_WIDTH/8.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rstn_i, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports m0_req_i / m1_req_i, input, 1 each, master request (m0 instruction, m1 data).
REQ-006 SHALL have ports m0_addr_i / m1_addr_i, input, ADDR_WIDTH each, byte address.
REQ-007 SHALL have ports m0_we_i / m1_we_i, input, 1 each, 1 = write.
REQ-008 SHALL have ports m0_be_i / m1_be_i, input, DATA_WIDTH/8 each, byte enables.
REQ-009 SHALL have ports m0_wdata_i / m1_wdata_i, input, DATA_WIDTH each, write data.
REQ-010 SHALL have ports m0_gnt_o / m1_gnt_o, output, 1 each, request accepted this cycle.
REQ-011 SHALL have ports m0_rvalid_o / m1_rvalid_o, output, 1 each, response valid.
REQ-012 SHALL have ports m0_rdata_o / m1_rdata_o, output, DATA_WIDTH each, read data.
REQ-013 SHALL have ports ram_en_o, ram_we_o, output, 1 each, RAM enable / write.
REQ-014 SHALL have ports ram_addr_o (ADDR_WIDTH), ram_be_o (DATA_WIDTH/8), ram_wdata_o (DATA_WIDTH), outputs to RAM.
REQ-015 SHALL have port ram_rdata_i, input, DATA_WIDTH, RAM read data, valid one cycle after enabled read.
REQ-016 SHALL have port ram_bypass_en_o, output, 1, tied 0.

Function
REQ-017 Grant SHALL be combinational, same cycle as req; at most one gnt high per cycle; gnt only when req high.
REQ-018 Single requester SHALL be granted immediately, no bubble.
REQ-019 Both requesting SHALL grant the master not granted last (round-robin); priority register last_gnt updates only on a grant.
REQ-020 ram_en_o SHALL equal m0_gnt_o|m1_gnt_o; ram_addr/we/be/wdata SHALL be muxed from the granted master; when no grant, these SHALL drive 0.
REQ-021 Every granted transaction (read or write) SHALL produce exactly one rvalid to its owner exactly one cycle after gnt.
REQ-022 Response tracking SHALL use registers resp_valid, resp_owner, resp_is_read set on grant cycle, cleared next cycle absent new grant.
REQ-023 Back-to-back grants SHALL sustain one transaction per cycle, including alternating masters.
REQ-024 On read response, owner rdata_o SHALL equal ram_rdata_i; value SHALL be captured into per-master hold register.
REQ-025 Outside read-response cycles, and on write responses, mX_rdata_o SHALL present that master's hold register (last read data).
REQ-026 Non-owner rvalid SHALL be 0; a master's rdata SHALL never change due to the other master's traffic.
REQ-027 Write response: rvalid high, hold register unchanged.
REQ-028 Address SHALL pass unmodified (byte address); no alignment checking.

Reset
REQ-029 While rstn_i low: gnt_o, rvalid_o, ram_en_o, ram_we_o SHALL be 0; ram_addr/be/wdata 0; hold registers 0; last_gnt = m1 (so m0 wins first conflict).
REQ-030 Reset asserted with response pending SHALL drop it; no rvalid after release for pre-reset grants.
REQ-031 First grant allowed in first rising edge with rstn_i high.

Verification
REQ-032 m0 read addr 0x0010 alone -> m0_gnt same cycle, ram_en=1, ram_we=0, ram_addr=0x0010; next cycle m0_rvalid=1, m0_rdata=ram_rdata_i (e.g. 0xDEADBEEF).
REQ-033 Both req continuously after reset -> grants m0,m1,m0,m1...; each rvalid one cycle later to correct owner.
REQ-034 m1 write 0x0020, be=4'b0011, wdata=0x12345678 -> ram_we=1, ram_be=0011, ram_wdata=0x12345678; next cycle m1_rvalid=1, m1_rdata unchanged.
REQ-035 m0 read returns 0xA5A5A5A5, then m1 reads 0x11111111 -> m0_rdata stays 0xA5A5A5A5 throughout.
REQ-036 Grant m0 then rstn_i low before next edge -> no m0_rvalid, all outputs 0; after release, first conflict grants m0.
